// File: rtl/writeback_sched.sv
`default_nettype none
// ============================================================================
// Module   : writeback_sched
// Purpose  : Four-slot in-order writeback scheduler. It tracks issued
//            instructions until their result is known and their wait has
//            elapsed, retires them in order to the register-file write port,
//            and flags read-after-write hazards on pending destinations.
// Options  : WB_BYPASS_EN - when defined, an issue into an empty queue with
//            wait=0 and its data already known writes back in the same cycle
//            without allocating a slot.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_sched (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_valid,
  input  logic [1:0]  issue_rw,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_wait,
  input  logic        issue_data_valid,
  input  logic [31:0] issue_data,
  output logic        issue_ready,
  output logic [1:0]  issue_tag,
  input  logic        res_valid,
  input  logic [1:0]  res_tag,
  input  logic [31:0] res_data,
  output logic [1:0]  wb_rw,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic [5:0]  q_rs,
  input  logic [5:0]  q_rt,
  output logic        haz_s,
  output logic        haz_t
);

  localparam int unsigned DEPTH = 4;

  // Per-slot tracking state
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_dv;
  logic [1:0]       r_rw   [DEPTH];
  logic [4:0]       r_rd   [DEPTH];
  logic [4:0]       r_cnt  [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [1:0]       r_head;
  logic [1:0]       r_tail;
  logic [2:0]       r_occ;

  logic             w_alloc_rw;
  logic             w_bypass;
  logic             w_alloc;
  logic             w_retire;
  logic [DEPTH-1:0] w_match_s;
  logic [DEPTH-1:0] w_match_t;

  // A full queue refuses issues even if the head retires this cycle.
  assign issue_ready = (r_occ != 3'd4);
  assign issue_tag   = r_tail;
  assign w_alloc_rw  = (issue_rw == 2'b01) || (issue_rw == 2'b10);

`ifdef WB_BYPASS_EN
  assign w_bypass = issue_valid && (r_occ == 3'd0) && w_alloc_rw &&
                    (issue_wait == 5'd0) && issue_data_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_alloc  = issue_valid && issue_ready && w_alloc_rw && !w_bypass;
  assign w_retire = r_valid[r_head] && (r_cnt[r_head] == 5'd0) && r_dv[r_head];

  // Writeback port: retiring head first, bypassed issue otherwise, else idle.
  always_comb begin
    wb_rw   = 2'b00;
    wb_rd   = 5'd0;
    wb_data = 32'd0;
    if (w_retire) begin
      wb_rw   = r_rw[r_head];
      wb_rd   = r_rd[r_head];
      wb_data = r_data[r_head];
    end else if (w_bypass) begin
      wb_rw   = issue_rw;
      wb_rd   = issue_rd;
      wb_data = issue_data;
    end
  end

  // Hazard match per slot; the retiring head is excluded because its value
  // is forwarded downstream in the same cycle.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_haz
      logic w_live;
      assign w_live       = r_valid[i] && !(w_retire && (r_head == 2'(i)));
      assign w_match_s[i] = w_live && ({(r_rw[i] == 2'b10), r_rd[i]} == q_rs);
      assign w_match_t[i] = w_live && ({(r_rw[i] == 2'b10), r_rd[i]} == q_rt);
    end
  endgenerate

  // GPR 0 is hardwired, so it never carries a hazard.
  assign haz_s = (|w_match_s) && (q_rs != 6'd0);
  assign haz_t = (|w_match_t) && (q_rt != 6'd0);

  // Queue state: countdown, late results, retire at head, allocate at tail.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      r_dv    <= '0;
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
      r_occ   <= 3'd0;
      for (int k = 0; k < DEPTH; k++) begin
        r_rw[k[1:0]]   <= 2'b00;
        r_rd[k[1:0]]   <= 5'd0;
        r_cnt[k[1:0]]  <= 5'd0;
        r_data[k[1:0]] <= 32'd0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (r_valid[k[1:0]] && (r_cnt[k[1:0]] != 5'd0))
          r_cnt[k[1:0]] <= r_cnt[k[1:0]] - 5'd1;
      end
      // First result wins; a slot that already has data ignores later ones.
      if (res_valid && r_valid[res_tag] && !r_dv[res_tag]) begin
        r_dv[res_tag]   <= 1'b1;
        r_data[res_tag] <= res_data;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 2'd1;
      end
      // The tail slot is never valid here, so this cannot collide with the
      // retire or result updates above.
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_rw[r_tail]    <= issue_rw;
        r_rd[r_tail]    <= issue_rd;
        r_cnt[r_tail]   <= issue_wait;
        r_dv[r_tail]    <= issue_data_valid;
        r_data[r_tail]  <= issue_data;
        r_tail          <= r_tail + 2'd1;
      end
      r_occ <= r_occ + {2'b00, w_alloc} - {2'b00, w_retire};
    end
  end

endmodule
`default_nettype wire

// File: doc/writeback_sched.md
WRITEBACK_SCHED -- requirements
Module: writeback_sched

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port issue_valid  input  1  decoded instruction presented for tracking.
REQ-004 SHALL have ports issue_rw  input  2 (00 none, 01 GPR, 10 FPR, 11 reserved/none) and issue_rd  input  5, giving the destination.
REQ-005 SHALL have port issue_wait  input  5  extra cycles before the result may retire (0..31).
REQ-006 SHALL have ports issue_data_valid  input  1 and issue_data  input  32, carrying a result already known at issue.
REQ-007 SHALL have ports issue_ready  output  1 and issue_tag  output  2, the slot index the accepted issue is given.
REQ-008 SHALL have ports res_valid  input  1, res_tag  input  2 and res_data  input  32, carrying a late result from a multi-cycle unit.
REQ-009 SHALL have ports wb_rw  output  2, wb_rd  output  5 and wb_data  output  32, the register-file write port (same encoding as issue_rw).
REQ-010 SHALL have ports q_rs, q_rt  input  6 ({bank: 1=FPR, reg}) and haz_s, haz_t  output  1, the hazard flags.

Function
REQ-011 SHALL hold a 4-entry circular in-order queue; each entry holds valid, rw, rd, count[4:0], dvalid and data[31:0].
REQ-012 SHALL accept an issue when issue_valid && issue_ready && issue_rw is 01 or 10; other rw values are accepted but allocate nothing.
REQ-013 SHALL drive issue_ready = (occupancy != 4); a retire in the same cycle does not free a slot for that cycle's issue.
REQ-014 SHALL drive issue_tag with the tail index, load count=issue_wait, dvalid=issue_data_valid and data=issue_data on allocation, then advance the tail modulo 4.
REQ-015 SHALL decrement every valid entry's count by 1 per cycle, saturating at 0; decrement starts the cycle after allocation.
REQ-016 SHALL, on res_valid, set dvalid and data of entry res_tag if it is valid with dvalid=0; otherwise the result is ignored (the first result wins).
REQ-017 SHALL make the head entry retirable when valid, count==0 and dvalid==1; at most one retire per cycle, strictly in order.
REQ-018 SHALL drive wb_rw/wb_rd/wb_data combinationally from a retirable head, else 00/0/0; the head is freed at the end of that cycle.
REQ-019 SHALL make an entry allocated with wait=0 and dvalid=1 retirable in the cycle after issue (1-cycle latency).
REQ-020 SHALL assert haz_s (haz_t) when q_rs (q_rt) matches {rw==10, rd} of any valid entry that is not retiring this cycle; the retiring entry is covered by downstream forwarding.
REQ-021 SHALL never assert a hazard for q = 6'b000000 (GPR 0).
REQ-022 SHALL, for simultaneous issue, result and retire, apply all three in one cycle; a res_valid to the head in the same cycle does not make it retirable until the next cycle.

Reset
REQ-023 SHALL, while rstn=0, clear all entries, head, tail and occupancy, giving issue_ready=1, issue_tag=0, wb_rw=00, wb_rd=0, wb_data=0, haz_s=haz_t=0.
REQ-024 SHALL discard in-flight entries on reset mid-operation, with no writeback of them after rstn rises.

Configuration
REQ-025 SHALL implement macro WB_BYPASS_EN: when it is defined, an issue with the queue empty, rw 01/10, wait=0 and issue_data_valid=1 drives wb_* combinationally in the same cycle and allocates nothing.
REQ-026 SHALL, when WB_BYPASS_EN is undefined, route every allocating issue through the queue, giving a minimum latency of 1 cycle.

Verification
REQ-027 SHALL cover: issue rw=01 rd=5 wait=0 data=0x1234 dvalid=1 at cycle 0 -> wb_rw=01 wb_rd=5 wb_data=0x1234 at cycle 1 (at cycle 0 with WB_BYPASS_EN).
REQ-028 SHALL cover: issue rw=10 rd=3 wait=5 dvalid=0 tag=0, then res_tag=0 data=0x3F800000 at cycle 2 -> writeback at cycle 6 only; q_rt=6'h23 gives haz_t=1 in cycles 1..5 and 0 in cycle 6.
REQ-029 SHALL cover: issue wait=5 (rd=1), then wait=0 dvalid (rd=2) -> rd=1 retires before rd=2 (in order), with rd=2 retiring the cycle after rd=1.
REQ-030 SHALL cover: 4 allocating issues with no results -> issue_ready=0; a fifth issue_valid is not accepted and the tail does not move.
REQ-031 SHALL cover: rstn pulled low with 3 entries pending -> all outputs are at reset values immediately, and no wb_rw!=00 occurs before a new issue.
REQ-032 SHALL cover: issue rw=01 rd=0 -> haz_s=0 for q_rs=0 while the entry is pending, and res_valid to an empty tag leaves the state unchanged.
